// File: rtl/d_mem_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores with sign or zero extension,
// misalignment rejection and a fixed wait-state latency reported through stall.
module d_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  misaligned,
  output logic                  stall
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LOW_W = IDX_W + 2;
  localparam int LANES = DATA_WIDTH / 8;
  localparam bit SINGLE = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [LOW_W-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  store_q, store_d;
  logic                  load_q, load_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic                  req, is_load_in, mis_in, accept;
  logic                  use_live, access_en, wr_en;
  logic [LOW_W-1:0]      acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [1:0]            acc_size;
  logic                  acc_uns, acc_store, acc_load;
  logic [IDX_W-1:0]      acc_idx;
  logic [1:0]            acc_lane;
  logic [LANES-1:0]      byte_en;
  logic [DATA_WIDTH-1:0] lane_data, rd_word, rd_shift, load_val;
  logic [15:0]           rd_half;
  logic                  unused_addr_hi;

  // Requests are ignored while reset is held so stall cannot leak out.
  assign req        = reset & (memread | memwrite);
  assign is_load_in = memread & ~memwrite;
  assign mis_in     = ((mem_size == 2'b01) & address[0]) | (mem_size[1] & (|address[1:0]));
  assign accept     = (state_q == IDLE) & req;
  assign unused_addr_hi = ^address[ADDR_WIDTH-1:LOW_W];

  // A single-cycle access uses the live inputs; wait-state accesses use the captured copy.
  assign use_live  = (state_q == IDLE);
  assign acc_addr  = use_live ? address[LOW_W-1:0] : addr_q;
  assign acc_wdata = use_live ? write_data : wdata_q;
  assign acc_size  = use_live ? mem_size : size_q;
  assign acc_uns   = use_live ? mem_unsigned : uns_q;
  assign acc_store = use_live ? memwrite : store_q;
  assign acc_load  = use_live ? is_load_in : load_q;
  assign acc_idx   = acc_addr[LOW_W-1:2];
  assign acc_lane  = acc_addr[1:0];

  assign access_en = reset & ((SINGLE & accept & ~mis_in) |
                              ((state_q == WAIT) & (cnt_q == 4'd1)));
  assign wr_en     = access_en & acc_store;

  always_comb begin
    byte_en   = '1;
    lane_data = acc_wdata;
    case (acc_size)
      2'b00: begin
        byte_en   = 4'b0001 << acc_lane;
        lane_data = {LANES{acc_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = acc_lane[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en && byte_en[gi]) mem[acc_idx] <= lane_data[8*gi +: 8];
      end
      assign rd_word[8*gi +: 8] = mem[acc_idx];
    end
  endgenerate

  always_comb begin
    rd_shift = rd_word >> {acc_lane, 3'b000};
    rd_half  = acc_lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    case (acc_size)
      2'b00:   load_val = acc_uns ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = acc_uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    store_d     = store_q;
    load_d      = load_q;
    mis_d       = mis_q;
    read_data_d = read_data_q;
    stall       = 1'b0;
    read_valid  = 1'b0;
    misaligned  = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          addr_d  = address[LOW_W-1:0];
          wdata_d = write_data;
          size_d  = mem_size;
          uns_d   = mem_unsigned;
          store_d = memwrite;
          load_d  = is_load_in;
          mis_d   = mis_in;
          if (mis_in) begin
            state_d = DONE;
            if (is_load_in) read_data_d = '0;
          end else if (SINGLE) begin
            state_d = DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        read_valid = load_q & ~mis_q;
        misaligned = mis_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (access_en && acc_load) read_data_d = load_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      store_q     <= 1'b0;
      load_q      <= 1'b0;
      mis_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      store_q     <= store_d;
      load_q      <= load_d;
      mis_q       <= mis_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Bench for d_mem_ctrl: one LATENCY=1 and one LATENCY=3 instance, table-driven requests
// checked through a per-instance expected-output queue, plus reset and hold sequences.
module tb_d_mem_ctrl;

  localparam int K_NONE = 0;
  localparam int K_LOAD = 1;
  localparam int K_MIS  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0][31:0] address, write_data, read_data;
  logic [1:0]       memwrite, memread, mem_unsigned, read_valid, misaligned, stall;
  logic [1:0][1:0]  mem_size;

  int n_cmp = 0;
  int n_bad = 0;

  d_mem_ctrl #(.LATENCY(1)) dut0 (
    .clk(clk), .reset(rst_n[0]), .address(address[0]), .write_data(write_data[0]),
    .memwrite(memwrite[0]), .memread(memread[0]), .mem_size(mem_size[0]),
    .mem_unsigned(mem_unsigned[0]), .read_data(read_data[0]), .read_valid(read_valid[0]),
    .misaligned(misaligned[0]), .stall(stall[0])
  );

  d_mem_ctrl #(.LATENCY(3)) dut1 (
    .clk(clk), .reset(rst_n[1]), .address(address[1]), .write_data(write_data[1]),
    .memwrite(memwrite[1]), .memread(memread[1]), .mem_size(mem_size[1]),
    .mem_unsigned(mem_unsigned[1]), .read_data(read_data[1]), .read_valid(read_valid[1]),
    .misaligned(misaligned[1]), .stall(stall[1])
  );

  typedef struct {
    bit          d;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    int          kind;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  vec_t tbl[$];

  function automatic vec_t mk(bit d, logic rd, logic wr, logic [1:0] sz, logic uns,
                              logic [31:0] addr, logic [31:0] wd, int kind,
                              logic [31:0] exp_data, int exp_stall);
    vec_t v;
    v.d = d; v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.kind = kind; v.exp_data = exp_data; v.exp_stall = exp_stall;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic int sb_size(bit d);
    return d ? sb1.size() : sb0.size();
  endfunction

  // Compare any output pulse against the oldest expectation for that instance.
  task automatic mon(bit d);
    exp_t e;
    int   got;
    if (read_valid[d] || misaligned[d]) begin
      got = misaligned[d] ? (read_valid[d] ? 3 : K_MIS) : K_LOAD;
      if (sb_size(d) == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output dut%0d: got kind %0d, expected none", d, got);
      end else begin
        e = d ? sb1.pop_front() : sb0.pop_front();
        check($sformatf("out_kind dut%0d", d), 32'(got), 32'(e.kind));
        if (e.kind == K_LOAD) check($sformatf("read_data dut%0d", d), read_data[d], e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  task automatic scramble(bit d);
    address[d]      = $urandom;
    write_data[d]   = $urandom;
    mem_size[d]     = 2'($urandom);
    mem_unsigned[d] = 1'($urandom);
    memread[d]      = 1'b0;
    memwrite[d]     = 1'b0;
  endtask

  // Starts and ends just after a rising edge, with the instance back in IDLE.
  task automatic run_req(vec_t v);
    exp_t e;
    int   st;
    if (v.kind != K_NONE) begin
      e.kind = v.kind;
      e.data = v.exp_data;
      if (v.d) sb1.push_back(e); else sb0.push_back(e);
    end
    address[v.d]      = v.addr;
    write_data[v.d]   = v.wd;
    mem_size[v.d]     = v.sz;
    mem_unsigned[v.d] = v.uns;
    memread[v.d]      = v.rd;
    memwrite[v.d]     = v.wr;
    st = 0;
    @(negedge clk);
    if (stall[v.d]) st++;
    @(posedge clk);
    #1;
    scramble(v.d);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall[v.d]) break;
      st++;
    end
    @(posedge clk);
    #1;
    check("stall_cycles", 32'(st), 32'(v.exp_stall));
    check("expected_drained", 32'(sb_size(v.d)), 32'd0);
    if (v.d) sb1.delete(); else sb0.delete();
    $display("txn dut%0d rd=%0b wr=%0b size=%0d uns=%0b addr=0x%08h wd=0x%08h stall=%0d rdata=0x%08h",
             v.d, v.rd, v.wr, v.sz, v.uns, v.addr, v.wd, st, read_data[v.d]);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 2'b00;
    address      = '0;
    write_data   = '0;
    memwrite     = 2'b00;
    memread      = 2'b11;
    mem_size     = '0;
    mem_unsigned = 2'b00;

    // Fills the vector table: instance, rd, wr, size, unsigned, addr, wdata, kind, data, stalls.
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'h08,  32'h0000_0000, K_NONE, 0, 1));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'h0A,  32'h0000_1100, K_MIS,  0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h08,  0, K_LOAD, 32'h0000_0000, 1));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'h08,  32'h0000_1100, K_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h08,  0, K_LOAD, 32'h0000_1100, 1));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'h10,  32'h1122_3344, K_NONE, 0, 1));
    tbl.push_back(mk(0, 0, 1, 2'b00, 0, 32'h11,  32'h1234_56AB, K_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h10,  0, K_LOAD, 32'h1122_AB44, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 32'h11,  0, K_LOAD, 32'hFFFF_FFAB, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 32'h11,  0, K_LOAD, 32'h0000_00AB, 1));
    tbl.push_back(mk(0, 1, 0, 2'b01, 0, 32'h12,  0, K_LOAD, 32'h0000_1122, 1));
    tbl.push_back(mk(0, 1, 0, 2'b01, 0, 32'h10,  0, K_LOAD, 32'hFFFF_AB44, 1));
    tbl.push_back(mk(0, 1, 0, 2'b01, 1, 32'h10,  0, K_LOAD, 32'h0000_AB44, 1));
    tbl.push_back(mk(0, 0, 1, 2'b01, 0, 32'h12,  32'h9999_BEEF, K_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b10, 1, 32'h10,  0, K_LOAD, 32'hBEEF_AB44, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 32'h13,  0, K_LOAD, 32'h0000_00BE, 1));
    tbl.push_back(mk(0, 1, 0, 2'b01, 0, 32'h12,  0, K_LOAD, 32'hFFFF_BEEF, 1));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'h400, 32'hCAFE_F00D, K_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'h000, 0, K_LOAD, 32'hCAFE_F00D, 1));
    tbl.push_back(mk(0, 1, 1, 2'b00, 0, 32'h30,  32'hAAAA_AA55, K_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 32'h30,  0, K_LOAD, 32'h0000_0055, 1));
    tbl.push_back(mk(0, 1, 0, 2'b11, 0, 32'h02,  0, K_MIS, 0, 1));
    tbl.push_back(mk(0, 0, 1, 2'b01, 0, 32'h13,  32'h0000_7777, K_MIS, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 32'h13,  0, K_LOAD, 32'h0000_00BE, 1));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 32'h20,  32'hDEAD_BEEF, K_NONE, 0, 3));
    tbl.push_back(mk(1, 1, 0, 2'b10, 0, 32'h20,  0, K_LOAD, 32'hDEAD_BEEF, 3));
    tbl.push_back(mk(1, 1, 0, 2'b01, 0, 32'h21,  0, K_MIS, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 32'h40,  32'h0000_0000, K_NONE, 0, 3));
    tbl.push_back(mk(1, 1, 0, 2'b00, 0, 32'h23,  0, K_LOAD, 32'hFFFF_FFDE, 3));

    // Reset state, with read requests held high to show they are ignored.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_stall",      32'(stall[d]),      32'd0);
      check("reset_read_valid", 32'(read_valid[d]), 32'd0);
      check("reset_misaligned", 32'(misaligned[d]), 32'd0);
      check("reset_read_data",  read_data[d],       32'd0);
    end
    memread = 2'b00;
    @(negedge clk);
    rst_n = 2'b11;
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_req(tbl[i]);

    // Stores leave read_data alone; a rejected load clears it.
    run_req(mk(0, 1, 0, 2'b10, 0, 32'h10, 0, K_LOAD, 32'hBEEF_AB44, 1));
    run_req(mk(0, 0, 1, 2'b10, 0, 32'h50, 32'h0000_0077, K_NONE, 0, 1));
    check("store_keeps_read_data", read_data[0], 32'hBEEF_AB44);
    run_req(mk(0, 1, 0, 2'b01, 0, 32'h11, 0, K_MIS, 0, 1));
    check("misaligned_load_zero", read_data[0], 32'h0000_0000);

    // Reset in the middle of a wait-state store aborts it.
    address[1]    = 32'h40;
    write_data[1] = 32'h1234_5678;
    mem_size[1]   = 2'b10;
    memwrite[1]   = 1'b1;
    @(posedge clk);
    #1;
    scramble(1'b1);
    check("wait_stall", 32'(stall[1]), 32'd1);
    #2;
    rst_n[1]   = 1'b0;
    memread[1] = 1'b1;
    #1;
    check("abort_stall",      32'(stall[1]),      32'd0);
    check("abort_read_valid", 32'(read_valid[1]), 32'd0);
    check("abort_misaligned", 32'(misaligned[1]), 32'd0);
    check("abort_read_data",  read_data[1],       32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("held_stall", 32'(stall[1]), 32'd0);
    memread[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    run_req(mk(1, 1, 0, 2'b10, 0, 32'h40, 0, K_LOAD, 32'h0000_0000, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
